// File: rtl/adder_io_stage.sv
// adder_io_stage: registered I/O wrapper around an external combinational adder.
//   - An operand register feeds the adder directly (no input-to-adder comb path).
//   - A result register captures the adder output with a valid/ready handshake.
//   - A wrapping counter records results delivered downstream.
// Optional feature: define ADDER_OVF_FLAG_EN to add the registered signed
// overflow output out_ovf.
// N must be a multiple of 4 and at least 4.
module adder_io_stage #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  // upstream operand handshake
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_cin,
  // external adder
  output logic [N-1:0]     add_a,
  output logic [N-1:0]     add_b,
  output logic             add_cin,
  input  logic [N-1:0]     add_sum,
  input  logic             add_cout,
  // downstream result handshake
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_cout,
`ifdef ADDER_OVF_FLAG_EN
  output logic             out_ovf,
`endif
  output logic [CNT_W-1:0] op_count
);

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
  } opnd_t;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
  } res_t;

  opnd_t            opnd_q, opnd_d;
  logic             op_v_q, op_v_d;
  res_t             res_q, res_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             res_load;   // operand set moves into the result register
  logic             in_xfer;    // upstream transfer this cycle
  logic             out_xfer;   // downstream transfer this cycle

  // Handshake decode: the result register can take a new value when it is
  // empty or being drained this cycle; the operand register can take a new
  // set when empty or being emptied into the result register this cycle.
  always_comb begin
    res_load = op_v_q && (!out_valid_q || out_ready);
    in_ready = !op_v_q || res_load;
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid_q && out_ready;
  end

  // Operand register next state: a new set replaces the old one when both a
  // load and a transfer happen together, so op_v stays set in that case.
  always_comb begin
    opnd_d = opnd_q;
    op_v_d = op_v_q;
    if (in_xfer) begin
      opnd_d.a   = in_a;
      opnd_d.b   = in_b;
      opnd_d.cin = in_cin;
      op_v_d     = 1'b1;
    end else if (res_load) begin
      op_v_d     = 1'b0;
    end
  end

  // Operand register and its valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opnd_q <= '0;
      op_v_q <= 1'b0;
    end else begin
      opnd_q <= opnd_d;
      op_v_q <= op_v_d;
    end
  end

  // The adder sees only registered operands.
  always_comb begin
    add_a   = opnd_q.a;
    add_b   = opnd_q.b;
    add_cin = opnd_q.cin;
  end

  // Result register next state: capture on load, otherwise hold; valid drops
  // only when the held result is consumed and nothing replaces it.
  always_comb begin
    res_d       = res_q;
    out_valid_d = out_valid_q;
    if (res_load) begin
      res_d.sum   = add_sum;
      res_d.cout  = add_cout;
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // Result register and its valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Delivered-result counter; natural wrap at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (out_xfer) cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

`ifdef ADDER_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  // Signed overflow: like-signed operands producing a differently-signed sum.
  // Registered alongside the sum so it always describes the held result.
  always_comb begin
    ovf_d = ovf_q;
    if (res_load)
      ovf_d = (add_a[N-1] == add_b[N-1]) && (add_sum[N-1] != add_a[N-1]);
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign out_ovf = ovf_q;
`endif

  assign out_valid = out_valid_q;
  assign out_sum   = res_q.sum;
  assign out_cout  = res_q.cout;
  assign op_count  = cnt_q;

endmodule
